// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - byte-stream boot loader that fills instruction memory and releases core reset
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check.
module imem_program_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CHECK, S_RUN, S_ERROR
    } state_t;
    localparam state_t S_AFTER_PAYLOAD = S_CHECK;
    localparam logic   CHECK_EN        = 1'b1;
`else
    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_RUN, S_ERROR
    } state_t;
    localparam state_t S_AFTER_PAYLOAD = S_RUN;
    localparam logic   CHECK_EN        = 1'b0;
`endif

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            r_state;
    logic [15:0]       r_len;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_asm;
    logic              r_rx_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_core_rst;
    logic              r_load_done;
    logic              r_load_error;
    logic [ADDR_W:0]   r_words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    logic              w_accept;
    logic [15:0]       w_len;
    logic [ADDR_W:0]   w_next_count;
    logic              w_last_word;

    assign w_accept     = rx_valid && r_rx_ready;
    assign w_len        = {r_len[15:8], rx_data};
    assign w_next_count = r_words_loaded + (ADDR_W+1)'(1);
    assign w_last_word  = ({1'b0, r_len} == 17'(w_next_count));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_LEN_HI;
            r_len          <= '0;
            r_byte_cnt     <= '0;
            r_asm          <= '0;
            r_rx_ready     <= 1'b1;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= '0;
            r_core_rst     <= 1'b1;
            r_load_done    <= 1'b0;
            r_load_error   <= 1'b0;
            r_words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor          <= '0;
`endif
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        r_state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        if ({1'b0, w_len} > MAX_WORDS) begin
                            r_state      <= S_ERROR;
                            r_rx_ready   <= 1'b0;
                            r_load_error <= 1'b1;
                        end else if (w_len == 16'd0) begin
                            r_state    <= S_AFTER_PAYLOAD;
                            r_rx_ready <= CHECK_EN;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor <= r_xor ^ rx_data;
`endif
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_asm      <= {r_asm[15:0], rx_data};
                        // Fourth byte completes the word: write it out the following cycle.
                        if (r_byte_cnt == 2'd3) begin
                            r_imem_we      <= 1'b1;
                            r_imem_wdata   <= {r_asm, rx_data};
                            r_imem_addr    <= r_words_loaded[ADDR_W-1:0];
                            r_words_loaded <= w_next_count;
                            if (w_last_word) begin
                                r_state    <= S_AFTER_PAYLOAD;
                                r_rx_ready <= CHECK_EN;
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept) begin
                        r_rx_ready <= 1'b0;
                        if (rx_data == r_xor) begin
                            r_state <= S_RUN;
                        end else begin
                            r_state      <= S_ERROR;
                            r_load_error <= 1'b1;
                        end
                    end
                end
`endif
                S_RUN: begin
                    // Release one edge after entry so the last write has a full cycle to land.
                    if (r_core_rst) begin
                        r_core_rst  <= 1'b0;
                        r_load_done <= 1'b1;
                    end
                end
                S_ERROR: begin
                    r_rx_ready <= 1'b0;
                end
                default: begin
                    r_state      <= S_ERROR;
                    r_rx_ready   <= 1'b0;
                    r_load_error <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready     = r_rx_ready;
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign core_rst     = r_core_rst;
    assign load_done    = r_load_done;
    assign load_error   = r_load_error;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - self-checking bench for imem_program_loader
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_program_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;

    imem_program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .load_done(load_done), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model state: derived from the count of accepted image bytes.
    int          m_k;
    logic [15:0] m_n;
    logic [7:0]  m_xor;
    bit          m_err, m_run, m_last_acc;
    int          m_age, m_words;
    logic        m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0] m_wdata, m_acc;

    logic [31:0] mem [DEPTH];
    int  n_writes = 0;
    int  w_base = 0;
    int  last_we_cyc = 0;
    int  fall_cyc = 0;
    logic prev_core_rst = 1'b1;
    bit  chk_on = 1'b0;
    logic [7:0] img [$];

    function automatic bit m_ready();
        return !m_err && !m_run && (m_k < 2 || m_k < 2 + 4 * int'(m_n) + CHK);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        m_last_acc = 1'b0;
        if (!rst) begin
            m_k = 0; m_n = '0; m_xor = '0; m_err = 0; m_run = 0; m_age = 0;
            m_we = 0; m_addr = '0; m_wdata = '0; m_acc = '0; m_words = 0;
        end else begin
            m_we = 0;
            if (m_run) m_age++;
            if (rx_valid && m_ready()) begin
                m_last_acc = 1'b1;
                m_k++;
                if (m_k == 1) begin
                    m_n[15:8] = rx_data;
                end else if (m_k == 2) begin
                    m_n[7:0] = rx_data;
                    if (int'(m_n) > DEPTH) m_err = 1;
                    else if (m_n == 0 && CHK == 0) begin m_run = 1; m_age = 0; end
                end else if (m_k <= 2 + 4 * int'(m_n)) begin
                    m_acc = {m_acc[23:0], rx_data};
                    m_xor ^= rx_data;
                    if ((m_k - 2) % 4 == 0) begin
                        m_we = 1;
                        m_addr = ADDR_W'((m_k - 2) / 4 - 1);
                        m_wdata = m_acc;
                        m_words++;
                        if (m_k == 2 + 4 * int'(m_n) && CHK == 0) begin m_run = 1; m_age = 0; end
                    end
                end else begin
                    if (rx_data == m_xor) begin m_run = 1; m_age = 0; end
                    else m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("rx_ready", rx_ready, m_ready());
            check("imem_we", imem_we, m_we);
            check("imem_addr", imem_addr, m_addr);
            check("imem_wdata", imem_wdata, m_wdata);
            check("words_loaded", words_loaded, m_words);
            check("core_rst", core_rst, !(m_run && m_age >= 1));
            check("load_done", load_done, m_run && m_age >= 1);
            check("load_error", load_error, m_err);
            if (imem_we) begin
                mem[imem_addr] = imem_wdata;
                n_writes++;
                last_we_cyc = cyc;
            end
            if (prev_core_rst && !core_rst) fall_cyc = cyc;
            prev_core_rst = core_rst;
        end
    end

    task automatic reset_dut();
        rst = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        w_base = n_writes;
        chk_on = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_data = b;
        rx_valid = 1'b1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!m_last_acc && t < 50);
        check("accept_timeout", m_last_acc, 1'b1);
        rx_valid = 1'b0;
        rx_data = 8'h5A;
        idle(gap);
    endtask

    task automatic send_img(input int gap);
        for (int i = 0; i < img.size(); i++) send_byte(img[i], gap);
    endtask

    task automatic add_checksum();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < img.size(); i++) x ^= img[i];
        if (CHK != 0) img.push_back(x);
    endtask

    initial begin
        #1;
        reset_dut();
        check("reset_rx_ready", rx_ready, 1);
        check("reset_core_rst", core_rst, 1);
        check("reset_we", imem_we, 0);
        check("reset_wdata", imem_wdata, 0);
        check("reset_words", words_loaded, 0);

        // Two-word image, continuous valid
        img = {8'h00, 8'h02, 8'h20, 8'h22, 8'h00, 8'h05, 8'h04, 8'h43, 8'h00, 8'h40};
        add_checksum();
        send_img(0);
        idle(3);
        check("t1_mem0", mem[0], 32'h20220005);
        check("t1_mem1", mem[1], 32'h04430040);
        check("t1_writes", n_writes - w_base, 2);
        check("t1_words", words_loaded, 2);
        check("t1_done", load_done, 1);
        check("t1_core_rst", core_rst, 0);
        check("t1_release_lag", fall_cyc - last_we_cyc, 1 + CHK);

        // Same image with 3-cycle gaps
        reset_dut();
        send_img(3);
        idle(3);
        check("t2_mem0", mem[0], 32'h20220005);
        check("t2_mem1", mem[1], 32'h04430040);
        check("t2_writes", n_writes - w_base, 2);
        check("t2_done", load_done, 1);

        // Empty image
        reset_dut();
        img = {8'h00, 8'h00};
        add_checksum();
        send_img(0);
        check("t3_core_rst_held", core_rst, 1);
        check("t3_done_early", load_done, 0);
        idle(1);
        check("t3_core_rst", core_rst, 0);
        check("t3_done", load_done, 1);
        check("t3_writes", n_writes - w_base, 0);

        // Oversize length rejected, further bytes ignored
        reset_dut();
        img = {8'h04, 8'h01};
        send_img(0);
        check("t4_error", load_error, 1);
        check("t4_rx_ready", rx_ready, 0);
        check("t4_core_rst", core_rst, 1);
        rx_data = 8'hAB;
        rx_valid = 1'b1;
        idle(10);
        rx_valid = 1'b0;
        idle(2);
        check("t4_writes", n_writes - w_base, 0);
        check("t4_words", words_loaded, 0);
        check("t4_error_sticky", load_error, 1);

        // Reset in the middle of a load, then a fresh one-word image
        reset_dut();
        img = {8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        send_img(0);
        reset_dut();
        img = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        add_checksum();
        send_img(0);
        idle(3);
        check("t5_mem0", mem[0], 32'h12345678);
        check("t5_writes", n_writes - w_base, 1);
        check("t5_words", words_loaded, 1);
        check("t5_done", load_done, 1);

        // Exactly full memory
        reset_dut();
        img = {8'h04, 8'h00};
        for (int j = 0; j < 4 * DEPTH; j++) img.push_back(8'(j));
        add_checksum();
        send_img(0);
        idle(3);
        check("t6_writes", n_writes - w_base, DEPTH);
        check("t6_words", words_loaded, DEPTH);
        check("t6_done", load_done, 1);
        check("t6_mem0", mem[0], 32'h00010203);
        check("t6_mem5", mem[5], 32'h14151617);
        check("t6_mem_last", mem[DEPTH-1], 32'hFCFDFEFF);

`ifdef IMEM_LOADER_CHECKSUM_EN
        reset_dut();
        img = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_img(0);
        idle(3);
        check("t7_done", load_done, 1);
        check("t7_error", load_error, 0);
        reset_dut();
        img = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_img(0);
        idle(3);
        check("t7b_error", load_error, 1);
        check("t7b_core_rst", core_rst, 1);
        check("t7b_done", load_done, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
